tri_bbox_scanner: RTL and testbench
===================================

// Module: tri_bbox_scanner
// PURPOSE
//   Upstream stage of the triangle inside-test pipeline.
//   Latches one triangle's three vertices on start, computes its screen-clamped bounding box,
//   then emits every pixel coordinate in that box, one per accepted beat, in raster order.
//   Downstream pipeline input: pixel_x/pixel_y. Held vertices: the inside-test's x0..y2.
// PARAMETERS
//   WIDTH   1280  screen width in pixels; legal x is 0..WIDTH-1
//   HEIGHT  720   screen height in pixels; legal y is 0..HEIGHT-1
// PORTS
//   pixel_clk    in   1   single clock, all state on rising edge
//   rst_n        in   1   asynchronous, active-low reset
//   start        in   1   request to rasterize the vertices on x0..y2
//   x0,y0,x1,y1,x2,y2 in 32 each  signed vertex coordinates, sampled only on accepted start
//   busy         out  1   high from accepted start until done
//   done         out  1   one-cycle pulse when the triangle's scan completes
//   vx0,vy0,vx1,vy1,vx2,vy2 out 32 each  latched vertices, stable while busy
//   pixel_x      out  32  current coordinate, unsigned, 0..WIDTH-1
//   pixel_y      out  32  current coordinate, unsigned, 0..HEIGHT-1
//   pixel_valid  out  1   pixel_x/pixel_y hold a pixel to deliver
//   pixel_ready  in   1   downstream accepts; a beat transfers when valid && ready
// BEHAVIOUR
//   Reset: every output is 0 and state is IDLE. Reset is async-asserted and applies mid-scan too;
//   no done pulse is generated for the aborted triangle.
//   FSM states: IDLE -> SETUP -> SCAN -> DONE -> IDLE; SETUP -> DONE when the bbox is empty.
//   IDLE: start=1 at edge N latches x0..y2 into vx*/vy*. busy=1 after edge N. start is ignored
//     in any state except IDLE.
//   SETUP (one cycle): compute the box from the vertices.
//     - xmin/xmax = signed min/max of x0,x1,x2; ymin/ymax likewise.
//     - Clamp to [0,WIDTH-1] and [0,HEIGHT-1].
//     - The box is empty if xmax<0, ymax<0, xmin>WIDTH-1 or ymin>HEIGHT-1.
//     - Edge N+1 registers the clamped box and sets pixel_x=xmin_c, pixel_y=ymin_c.
//     - If not empty, pixel_valid=1 after edge N+1.
//   SCAN: pixel_valid stays 1; pixel_x/pixel_y change only on a transfer beat.
//     - Beat with pixel_x<xmax_c: pixel_x+1.
//     - Beat with pixel_x==xmax_c: pixel_x=xmin_c, pixel_y+1.
//     - Beat on (xmax_c,ymax_c): pixel_valid=0, go to DONE.
//     - pixel_ready=0 stalls with outputs held (no drops, no duplicates).
//   DONE (one cycle): done=1 and busy=0 in the same cycle; then IDLE.
//     start may be accepted in the IDLE cycle after DONE (no back-to-back in DONE).
//   Arithmetic: comparisons are signed 32-bit; after clamping, values are non-negative and
//   fit WIDTH/HEIGHT. Box pixels = (xmax_c-xmin_c+1)*(ymax_c-ymin_c+1).
//     Zero-area and degenerate triangles still scan their box.
//   vx*/vy* hold until the next accepted start; they are not cleared at DONE.
//   First pixel_valid is 2 cycles after start; done comes 1 cycle after the last beat.
// STRUCTURE
//   Shared header: WIDTH/HEIGHT screen constants and FSM state encodings, shared with the
//   inside-test and framebuffer stages.
//   Sub-module tri_bbox (combinational): min/max over 3 signed values + clamp + empty flag,
//   instantiated once for x and once for y.
//   Parent holds FSM, vertex/box registers and x/y counters.
// TESTING
//   1. Start (500,50),(100,400),(700,300), pixel_ready=1 ->
//      - box x 100..700, y 50..400; exactly 210951 beats.
//      - first (100,50), last (700,400); done 1 cycle after the last beat.
//   2. Same triangle, pixel_ready toggled pseudo-randomly ->
//      - identical beat sequence; pixel_x/pixel_y stable during stalls.
//   3. Start (-20,-5),(1400,10),(30,800) ->
//      - box clamped to 0..1279 x 0..719; 921600 beats; last (1279,719).
//   4. Start (-50,-50),(-10,-40),(-30,-5) ->
//      - pixel_valid never 1; done pulses 2 cycles after start.
//   5. Start (5,5)x3 -> one beat (5,5), then done. A second start while busy is ignored.
//   6. rst_n low mid-scan of test 1 ->
//      - all outputs 0 immediately, no done.
//      - a new start after release scans from (xmin_c,ymin_c).

Source files
------------

// File: rtl/tri_bbox_scanner_pkg.sv
// Screen constants and scanner state encoding. The inside-test and
// framebuffer stages use the same constants.
package tri_bbox_scanner_pkg;

    localparam int unsigned WIDTH   = 1280;
    localparam int unsigned HEIGHT  = 720;
    localparam int unsigned COORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SCAN,
        ST_DONE
    } scan_state_t;

endpackage

// File: rtl/tri_bbox.sv
// Combinational per-axis bounding box for three signed vertices: signed
// min/max, a clamp to [0, LIMIT-1], and a flag for a box that lies
// entirely off screen.
module tri_bbox
    import tri_bbox_scanner_pkg::*;
#(
    parameter int unsigned LIMIT = WIDTH
) (
    input  logic signed [COORD_W-1:0] a,
    input  logic signed [COORD_W-1:0] b,
    input  logic signed [COORD_W-1:0] c,
    output logic        [COORD_W-1:0] lo,
    output logic        [COORD_W-1:0] hi,
    output logic                      empty
);

    localparam logic signed [COORD_W-1:0] TOP = COORD_W'(LIMIT - 1);

    logic signed [COORD_W-1:0] mn;
    logic signed [COORD_W-1:0] mx;

    // Signed extremes, then clamp each extreme into the screen range.
    always_comb begin
        mn = a;
        if (b < mn) mn = b;
        if (c < mn) mn = c;
        mx = a;
        if (b > mx) mx = b;
        if (c > mx) mx = c;

        empty = (mx < 0) || (mn > TOP);

        lo = '0;
        if (mn > TOP)     lo = TOP;
        else if (mn >= 0) lo = mn;

        hi = '0;
        if (mx > TOP)     hi = TOP;
        else if (mx >= 0) hi = mx;
    end

endmodule

// File: rtl/tri_bbox_scanner.sv
// Latches one triangle, computes its screen-clamped bounding box and walks
// every pixel of that box in raster order with a valid/ready handshake.
module tri_bbox_scanner
    import tri_bbox_scanner_pkg::*;
(
    input  logic                      pixel_clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic signed [COORD_W-1:0] x0,
    input  logic signed [COORD_W-1:0] y0,
    input  logic signed [COORD_W-1:0] x1,
    input  logic signed [COORD_W-1:0] y1,
    input  logic signed [COORD_W-1:0] x2,
    input  logic signed [COORD_W-1:0] y2,
    output logic                      busy,
    output logic                      done,
    output logic signed [COORD_W-1:0] vx0,
    output logic signed [COORD_W-1:0] vy0,
    output logic signed [COORD_W-1:0] vx1,
    output logic signed [COORD_W-1:0] vy1,
    output logic signed [COORD_W-1:0] vx2,
    output logic signed [COORD_W-1:0] vy2,
    output logic        [COORD_W-1:0] pixel_x,
    output logic        [COORD_W-1:0] pixel_y,
    output logic                      pixel_valid,
    input  logic                      pixel_ready
);

    scan_state_t state_q;
    scan_state_t state_d;

    logic [COORD_W-1:0] xmin_r;
    logic [COORD_W-1:0] xmax_r;
    logic [COORD_W-1:0] ymax_r;

    logic [COORD_W-1:0] x_lo;
    logic [COORD_W-1:0] x_hi;
    logic [COORD_W-1:0] y_lo;
    logic [COORD_W-1:0] y_hi;
    logic               x_empty;
    logic               y_empty;

    logic accept;
    logic beat;
    logic row_end;
    logic last_pix;

    // The box is computed from the latched vertices, which are stable in SETUP.
    tri_bbox #(.LIMIT(WIDTH)) u_bbox_x (
        .a     (vx0),
        .b     (vx1),
        .c     (vx2),
        .lo    (x_lo),
        .hi    (x_hi),
        .empty (x_empty)
    );

    tri_bbox #(.LIMIT(HEIGHT)) u_bbox_y (
        .a     (vy0),
        .b     (vy1),
        .c     (vy2),
        .lo    (y_lo),
        .hi    (y_hi),
        .empty (y_empty)
    );

    // State register.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state and status outputs decoded from the current state.
    always_comb begin
        state_d     = state_q;
        busy        = 1'b0;
        done        = 1'b0;
        pixel_valid = 1'b0;
        accept      = 1'b0;
        beat        = 1'b0;
        row_end     = (pixel_x == xmax_r);
        last_pix    = row_end && (pixel_y == ymax_r);
        case (state_q)
            ST_IDLE: begin
                accept = start;
                if (start) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                busy    = 1'b1;
                state_d = (x_empty || y_empty) ? ST_DONE : ST_SCAN;
            end
            ST_SCAN: begin
                busy        = 1'b1;
                pixel_valid = 1'b1;
                beat        = pixel_ready;
                if (pixel_ready && last_pix) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Vertex latch, box registers and the raster x/y counters.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            vx0     <= '0;
            vy0     <= '0;
            vx1     <= '0;
            vy1     <= '0;
            vx2     <= '0;
            vy2     <= '0;
            xmin_r  <= '0;
            xmax_r  <= '0;
            ymax_r  <= '0;
            pixel_x <= '0;
            pixel_y <= '0;
        end else begin
            if (accept) begin
                vx0 <= x0;
                vy0 <= y0;
                vx1 <= x1;
                vy1 <= y1;
                vx2 <= x2;
                vy2 <= y2;
            end
            if (state_q == ST_SETUP) begin
                xmin_r  <= x_lo;
                xmax_r  <= x_hi;
                ymax_r  <= y_hi;
                pixel_x <= x_lo;
                pixel_y <= y_lo;
            end
            // The final beat leaves the counters on (xmax, ymax).
            if (beat && !last_pix) begin
                if (row_end) begin
                    pixel_x <= xmin_r;
                    pixel_y <= pixel_y + 32'd1;
                end else begin
                    pixel_x <= pixel_x + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tri_bbox_scanner.sv
module tb_tri_bbox_scanner;

    localparam int W = 1280;
    localparam int H = 720;

    logic               pixel_clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic signed [31:0] x0, y0, x1, y1, x2, y2;
    logic               busy, done;
    logic signed [31:0] vx0, vy0, vx1, vy1, vx2, vy2;
    logic        [31:0] pixel_x, pixel_y;
    logic               pixel_valid;
    logic               pixel_ready;

    int vectors    = 0;
    int miscompares = 0;

    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];

    int  first_v, last_b, done_s, done_cnt, stalls_bad;
    bit  timed_out, busy_at_done;

    tri_bbox_scanner dut (
        .pixel_clk   (pixel_clk),
        .rst_n       (rst_n),
        .start       (start),
        .x0          (x0),
        .y0          (y0),
        .x1          (x1),
        .y1          (y1),
        .x2          (x2),
        .y2          (y2),
        .busy        (busy),
        .done        (done),
        .vx0         (vx0),
        .vy0         (vy0),
        .vx1         (vx1),
        .vy1         (vy1),
        .vx2         (vx2),
        .vy2         (vy2),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready)
    );

    always #5 pixel_clk = ~pixel_clk;

    // Reference: one axis of the clamped box from plain integer arithmetic.
    function automatic void axis_box(input int a, input int b, input int c, input int lim,
                                     output int lo, output int hi, output bit empty);
        int mn, mx;
        mn = (a < b) ? a : b;
        mn = (mn < c) ? mn : c;
        mx = (a > b) ? a : b;
        mx = (mx > c) ? mx : c;
        empty = (mx < 0) || (mn > lim - 1);
        lo = (mn < 0) ? 0 : ((mn > lim - 1) ? lim - 1 : mn);
        hi = (mx < 0) ? 0 : ((mx > lim - 1) ? lim - 1 : mx);
    endfunction

    // Reference: every pixel of the box in raster order.
    function automatic bit build_exp(input int a0, input int b0, input int a1,
                                     input int b1, input int a2, input int b2);
        int xl, xh, yl, yh;
        bit ex, ey;
        axis_box(a0, a1, a2, W, xl, xh, ex);
        axis_box(b0, b1, b2, H, yl, yh, ey);
        exp_q.delete();
        if (!(ex || ey))
            for (int y = yl; y <= yh; y++)
                for (int x = xl; x <= xh; x++)
                    exp_q.push_back({32'(y), 32'(x)});
        return ex || ey;
    endfunction

    task automatic do_start(input int a0, input int b0, input int a1,
                            input int b1, input int a2, input int b2);
        x0 = a0; y0 = b0; x1 = a1; y1 = b1; x2 = a2; y2 = b2;
        start = 1'b1;
        @(posedge pixel_clk); #1;
        start = 1'b0;
    endtask

    // Records beats until done; sample s=0 is right after the accepting edge.
    task automatic collect(input int ready_pct, input bit poke, input int budget);
        logic [31:0] hx, hy;
        bit prev_stall;
        got_q.delete();
        first_v = -1; last_b = -1; done_s = -1; done_cnt = 0; stalls_bad = 0;
        timed_out = 1'b1; busy_at_done = 1'b0; prev_stall = 1'b0; hx = '0; hy = '0;
        for (int s = 0; s < budget; s++) begin
            if (prev_stall && (pixel_x !== hx || pixel_y !== hy || pixel_valid !== 1'b1))
                stalls_bad++;
            if (poke) begin
                start = (s == 1 || s == 2);
                if (s == 1) begin
                    x0 = 999; y0 = 333; x1 = 998; y1 = 332; x2 = 997; y2 = 331;
                end
            end
            if (done === 1'b1) begin
                done_cnt++; done_s = s; busy_at_done = busy; timed_out = 1'b0;
                break;
            end
            if (pixel_valid === 1'b1 && first_v < 0) first_v = s;
            pixel_ready = ($urandom_range(99) < 32'(ready_pct));
            if (pixel_valid === 1'b1 && pixel_ready) begin
                got_q.push_back({pixel_y, pixel_x});
                last_b = s;
            end
            prev_stall = (pixel_valid === 1'b1) && !pixel_ready;
            hx = pixel_x; hy = pixel_y;
            @(posedge pixel_clk); #1;
        end
        pixel_ready = 1'b0;
        @(posedge pixel_clk); #1;
        start = 1'b0;
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic test_reset();
        vectors++;
        if ({busy, done, pixel_valid, pixel_x, pixel_y, vx0, vy0, vx1, vy1, vx2, vy2} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b valid=%b px=%0d py=%0d vx0=%0d want all 0",
                     busy, done, pixel_valid, pixel_x, pixel_y, vx0);
        end
    endtask

    task automatic test_basic();
        void'(build_exp(50, 5, 10, 40, 70, 30));
        do_start(50, 5, 10, 40, 70, 30);
        vectors++;
        if (busy !== 1'b1 || pixel_valid !== 1'b0 || {vx0, vy0, vx1, vy1, vx2, vy2} !==
            {32'sd50, 32'sd5, 32'sd10, 32'sd40, 32'sd70, 32'sd30}) begin
            miscompares++;
            $display("FAIL basic_latch: busy=%b valid=%b vx0=%0d vy1=%0d want busy=1 valid=0 50/40",
                     busy, pixel_valid, vx0, vy1);
        end
        collect(100, 1'b0, 20000);
        vectors++;
        if (timed_out || got_q.size() != 2196) begin
            miscompares++;
            $display("FAIL basic_count: got %0d beats timeout=%b want 2196", got_q.size(), timed_out);
        end
        foreach (got_q[i]) if (i < exp_q.size()) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                if (miscompares < 20) $display("FAIL basic_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (first_v != 1 || done_s != last_b + 1 || done_cnt != 1 || busy_at_done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_timing: first=%0d last=%0d done=%0d cnt=%0d busy=%b want 1,last+1,1,0",
                     first_v, last_b, done_s, done_cnt, busy_at_done);
        end
        vectors++;
        if (got_q.size() > 0 && (got_q[0] !== {32'd5, 32'd10} || got_q[$] !== {32'd40, 32'd70})) begin
            miscompares++;
            $display("FAIL basic_ends: first %h last %h want (10,5) (70,40)", got_q[0], got_q[$]);
        end
    endtask

    task automatic test_stall();
        void'(build_exp(50, 5, 10, 40, 70, 30));
        do_start(50, 5, 10, 40, 70, 30);
        collect(60, 1'b0, 20000);
        vectors++;
        if (timed_out || got_q.size() != exp_q.size() || stalls_bad != 0) begin
            miscompares++;
            $display("FAIL stall_count: beats=%0d stalls_bad=%0d timeout=%b want %0d,0,0",
                     got_q.size(), stalls_bad, timed_out, exp_q.size());
        end
        foreach (got_q[i]) if (i < exp_q.size()) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                if (miscompares < 20) $display("FAIL stall_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (done_s != last_b + 1 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL stall_done: done=%0d last=%0d cnt=%0d want last+1,1", done_s, last_b, done_cnt);
        end
    endtask

    task automatic test_clamp();
        int tri_v[2][6] = '{'{-20, -5, 14, 10, 3, 8}, '{1270, 712, 1400, 800, 1275, 700}};
        int want_n[2]   = '{165, 200};
        logic [63:0] want_last[2] = '{{32'd10, 32'd14}, {32'd719, 32'd1279}};
        for (int t = 0; t < 2; t++) begin
            void'(build_exp(tri_v[t][0], tri_v[t][1], tri_v[t][2], tri_v[t][3], tri_v[t][4], tri_v[t][5]));
            do_start(tri_v[t][0], tri_v[t][1], tri_v[t][2], tri_v[t][3], tri_v[t][4], tri_v[t][5]);
            collect(100, 1'b0, 5000);
            vectors++;
            if (timed_out || got_q.size() != want_n[t] || got_q[$] !== want_last[t]) begin
                miscompares++;
                $display("FAIL clamp%0d: beats=%0d last=%h want %0d last=%h", t, got_q.size(),
                         (got_q.size() > 0) ? got_q[$] : 64'h0, want_n[t], want_last[t]);
            end
            foreach (got_q[i]) if (i < exp_q.size()) begin
                vectors++;
                if (got_q[i] !== exp_q[i]) begin
                    miscompares++;
                    if (miscompares < 20) $display("FAIL clamp_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_empty();
        int tri_v[2][6] = '{'{-50, -50, -10, -40, -30, -5}, '{1300, 5, 1400, 6, 1290, 7}};
        for (int t = 0; t < 2; t++) begin
            do_start(tri_v[t][0], tri_v[t][1], tri_v[t][2], tri_v[t][3], tri_v[t][4], tri_v[t][5]);
            collect(100, 1'b0, 50);
            vectors++;
            if (timed_out || first_v != -1 || got_q.size() != 0 || done_s != 1 || done_cnt != 1) begin
                miscompares++;
                $display("FAIL empty%0d: first_valid=%0d beats=%0d done_at=%0d cnt=%0d want -1,0,1,1",
                         t, first_v, got_q.size(), done_s, done_cnt);
            end
        end
    endtask

    task automatic test_single_ignore();
        do_start(5, 5, 5, 5, 5, 5);
        collect(100, 1'b1, 50);
        vectors++;
        if (timed_out || got_q.size() != 1 || got_q[0] !== {32'd5, 32'd5} || done_s != 2) begin
            miscompares++;
            $display("FAIL single: beats=%0d done_at=%0d want 1 beat (5,5) done_at 2", got_q.size(), done_s);
        end
        vectors++;
        if (busy !== 1'b0 || vx0 !== 32'sd5 || vy2 !== 32'sd5) begin
            miscompares++;
            $display("FAIL ignore_start: busy=%b vx0=%0d vy2=%0d want 0 5 5", busy, vx0, vy2);
        end
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 2; t++) begin
            void'(build_exp(3 + t, 7, 6 + t, 9, 4, 8 + t));
            do_start(3 + t, 7, 6 + t, 9, 4, 8 + t);
            collect(100, 1'b0, 500);
            vectors++;
            if (timed_out || got_q != exp_q || vx1 !== 32'(6 + t)) begin
                miscompares++;
                $display("FAIL back_to_back%0d: beats=%0d vx1=%0d want %0d beats vx1=%0d",
                         t, got_q.size(), vx1, exp_q.size(), 6 + t);
            end
        end
    endtask

    task automatic test_random();
        int v[6];
        bit empty;
        for (int t = 0; t < 10; t++) begin
            int bx = int'($urandom_range(1340)) - 30;
            int by = int'($urandom_range(780)) - 30;
            for (int k = 0; k < 3; k++) begin
                v[2*k]   = bx + int'($urandom_range(24)) - 12;
                v[2*k+1] = by + int'($urandom_range(24)) - 12;
            end
            empty = build_exp(v[0], v[1], v[2], v[3], v[4], v[5]);
            do_start(v[0], v[1], v[2], v[3], v[4], v[5]);
            collect(70, 1'b0, 5000);
            vectors++;
            if (timed_out || got_q != exp_q || stalls_bad != 0 || done_cnt != 1) begin
                miscompares++;
                $display("FAIL random%0d (%0d,%0d)(%0d,%0d)(%0d,%0d): beats=%0d want %0d stalls_bad=%0d",
                         t, v[0], v[1], v[2], v[3], v[4], v[5], got_q.size(), exp_q.size(), stalls_bad);
            end
            vectors++;
            if (empty ? (done_s != 1) : (first_v != 1 || done_s != last_b + 1)) begin
                miscompares++;
                $display("FAIL random%0d_timing: first=%0d last=%0d done=%0d empty=%b",
                         t, first_v, last_b, done_s, empty);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        int seen_done = 0;
        do_start(50, 5, 10, 40, 70, 30);
        pixel_ready = 1'b1;
        repeat (100) begin @(posedge pixel_clk); #1; end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, pixel_valid, pixel_x, pixel_y, vx0, vy0, vx1, vy1, vx2, vy2} !== '0) begin
            miscompares++;
            $display("FAIL midscan_reset: busy=%b valid=%b px=%0d py=%0d vx0=%0d want all 0",
                     busy, pixel_valid, pixel_x, pixel_y, vx0);
        end
        pixel_ready = 1'b0;
        repeat (3) begin
            @(posedge pixel_clk); #1;
            if (done === 1'b1) seen_done++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge pixel_clk); #1;
            if (done === 1'b1) seen_done++;
        end
        vectors++;
        if (seen_done != 0) begin
            miscompares++;
            $display("FAIL midscan_no_done: done seen %0d cycles want 0", seen_done);
        end
        void'(build_exp(50, 5, 10, 40, 70, 30));
        do_start(50, 5, 10, 40, 70, 30);
        collect(100, 1'b0, 20000);
        vectors++;
        if (timed_out || got_q != exp_q) begin
            miscompares++;
            $display("FAIL midscan_restart: beats=%0d first=%h want %0d first=(10,5)",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 64'h0, exp_q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; pixel_ready = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; x2 = '0; y2 = '0;
        #1;
        test_reset();
        repeat (2) @(posedge pixel_clk);
        #1;
        rst_n = 1'b1;
        @(posedge pixel_clk); #1;
        test_basic();
        test_stall();
        test_clamp();
        test_empty();
        test_single_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
